// File: rtl/project_pkg.sv
// Shared types, dimension limits and ASCII constants for the matrix result printer.
package project_pkg;

  localparam int MAX_ROWS = 8;
  localparam int MAX_COLS = 10;
  localparam int ROW_W    = $clog2(MAX_ROWS + 1);
  localparam int COL_W    = $clog2(MAX_COLS + 1);
  localparam int RIDX_W   = $clog2(MAX_ROWS);
  localparam int CIDX_W   = $clog2(MAX_COLS);

  typedef logic signed [7:0] matrix_element_t;
  typedef matrix_element_t [MAX_ROWS-1:0][MAX_COLS-1:0] cells_t;

  typedef struct packed {
    logic [ROW_W-1:0] rows;
    logic [COL_W-1:0] cols;
    cells_t           cells;
    logic             is_valid;
  } matrix_t;

  localparam logic [7:0]  ASCII_CR    = 8'h0D;
  localparam logic [7:0]  ASCII_LF    = 8'h0A;
  localparam logic [7:0]  ASCII_MINUS = 8'h2D;
  localparam logic [7:0]  ASCII_ZERO  = 8'h30;
  localparam logic [23:0] ERR_STR     = 24'h455252;
  localparam int          ERR_LEN     = 3;

  typedef enum logic [3:0] {
    IDLE, SIGN, HUND, TENS, ONES, SEP, CR, LF, ERR_MSG, DONE
  } prn_state_e;

  typedef struct packed {
    prn_state_e st;
    logic [7:0] data;
  } step_t;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_ZERO + {4'd0, d};
  endfunction

  function automatic logic [7:0] err_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return ERR_STR[23:16];
      2'd1:    return ERR_STR[15:8];
      default: return ERR_STR[7:0];
    endcase
  endfunction

endpackage

// File: rtl/elem_to_digits.sv
// Splits a signed 8-bit element into sign, hundreds, tens, ones and a digit count
// using compare-and-subtract stages only.
module elem_to_digits
  import project_pkg::*;
(
  input  logic signed [7:0] elem_i,
  output logic              neg_o,
  output logic [3:0]        hund_o,
  output logic [3:0]        tens_o,
  output logic [3:0]        ones_o,
  output logic [1:0]        ndig_o
);

  logic [7:0] mag_s;
  logic [7:0] r1_s, r2_s, r3_s, r4_s;
  logic [3:0] r5_s;
  logic       h_s, t3_s, t2_s, t1_s, t0_s;

  // Magnitude 0..128 (the -128 case wraps to 8'h80 = 128), then binary-weighted tens stages.
  always_comb begin
    neg_o  = elem_i[7];
    mag_s  = elem_i[7] ? (~elem_i + 8'd1) : elem_i;
    h_s    = (mag_s >= 8'd100);
    r1_s   = h_s ? (mag_s - 8'd100) : mag_s;
    t3_s   = (r1_s >= 8'd80);
    r2_s   = t3_s ? (r1_s - 8'd80) : r1_s;
    t2_s   = (r2_s >= 8'd40);
    r3_s   = t2_s ? (r2_s - 8'd40) : r2_s;
    t1_s   = (r3_s >= 8'd20);
    r4_s   = t1_s ? (r3_s - 8'd20) : r3_s;
    t0_s   = (r4_s >= 8'd10);
    r5_s   = t0_s ? 4'(r4_s - 8'd10) : r4_s[3:0];
    hund_o = {3'd0, h_s};
    tens_o = {t3_s, t2_s, t1_s, t0_s};
    ones_o = r5_s;
    ndig_o = h_s ? 2'd3 : ((tens_o != 4'd0) ? 2'd2 : 2'd1);
  end

endmodule

// File: rtl/matrix_result_printer.sv
// Streams a snapshotted matrix as ASCII signed decimal rows (or "ERR") over a
// valid/ready byte interface, one byte per cycle when not stalled.
module matrix_result_printer
  import project_pkg::*;
#(
  parameter logic [7:0] SEP_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  matrix_t    result_matrix,
  input  logic       error_flag,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  prn_state_e        state_q, state_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [RIDX_W-1:0] row_q, row_d;
  logic [CIDX_W-1:0] col_q, col_d;
  logic [ROW_W-1:0]  rows_q;
  logic [COL_W-1:0]  cols_q;
  cells_t            cells_q;
  logic              err_q;
  logic              neg_q;
  logic [3:0]        hund_q, tens_q, ones_q;
  logic [1:0]        ndig_q;

  logic              ld_snap_s, ld_dig_s, xfer_s, last_col_s, last_row_s;
  logic [ROW_W-1:0]  rows_in_s;
  logic [COL_W-1:0]  cols_in_s;
  logic [RIDX_W-1:0] nrow_s;
  logic [CIDX_W-1:0] ncol_s;
  matrix_element_t   nxt_elem_s;
  logic              nd_neg_s;
  logic [3:0]        nd_hund_s, nd_tens_s, nd_ones_s;
  logic [1:0]        nd_ndig_s;
  step_t             nstep_s, cstep_s;

  // First byte of an element: sign if negative, otherwise its leading digit.
  function automatic step_t first_step(input logic neg, input logic [1:0] ndig,
                                       input logic [3:0] h, input logic [3:0] t,
                                       input logic [3:0] o);
    step_t s;
    if (neg) begin
      s = '{st: SIGN, data: ASCII_MINUS};
    end else if (ndig == 2'd3) begin
      s = '{st: HUND, data: ascii_digit(h)};
    end else if (ndig == 2'd2) begin
      s = '{st: TENS, data: ascii_digit(t)};
    end else begin
      s = '{st: ONES, data: ascii_digit(o)};
    end
    return s;
  endfunction

  assign rows_in_s  = (result_matrix.rows > ROW_W'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : result_matrix.rows;
  assign cols_in_s  = (result_matrix.cols > COL_W'(MAX_COLS)) ? COL_W'(MAX_COLS) : result_matrix.cols;
  assign xfer_s     = tx_valid_q & tx_ready;
  assign last_col_s = (COL_W'(col_q) == cols_q - COL_W'(1));
  assign last_row_s = (ROW_W'(row_q) == rows_q - ROW_W'(1));

  // Element whose first byte is produced next: after SEP it is the next column,
  // after LF the first column of the next row, from IDLE the live input cell 0,0.
  always_comb begin
    if (state_q == SEP) begin
      nrow_s = row_q;
      ncol_s = col_q + CIDX_W'(1);
    end else begin
      nrow_s = row_q + RIDX_W'(1);
      ncol_s = '0;
    end
    nxt_elem_s = (state_q == IDLE) ? result_matrix.cells[0][0] : cells_q[nrow_s][ncol_s];
  end

  elem_to_digits u_digits (
    .elem_i (nxt_elem_s),
    .neg_o  (nd_neg_s),
    .hund_o (nd_hund_s),
    .tens_o (nd_tens_s),
    .ones_o (nd_ones_s),
    .ndig_o (nd_ndig_s)
  );

  assign nstep_s = first_step(nd_neg_s, nd_ndig_s, nd_hund_s, nd_tens_s, nd_ones_s);
  assign cstep_s = first_step(1'b0, ndig_q, hund_q, tens_q, ones_q);

  // Next-state logic: every byte state holds until its byte transfers.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    row_d      = row_q;
    col_d      = col_q;
    ld_snap_s  = 1'b0;
    ld_dig_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ld_snap_s = 1'b1;
          row_d     = '0;
          col_d     = '0;
          if (error_flag || !result_matrix.is_valid) begin
            state_d    = ERR_MSG;
            tx_data_d  = err_byte(2'd0);
            tx_valid_d = 1'b1;
            busy_d     = 1'b1;
          end else if (rows_in_s == '0 || cols_in_s == '0) begin
            state_d    = DONE;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            tx_valid_d = 1'b0;
          end else begin
            state_d    = nstep_s.st;
            tx_data_d  = nstep_s.data;
            tx_valid_d = 1'b1;
            busy_d     = 1'b1;
            ld_dig_s   = 1'b1;
          end
        end else begin
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
        end
      end
      SIGN: begin
        if (xfer_s) begin
          state_d   = cstep_s.st;
          tx_data_d = cstep_s.data;
        end else begin
          state_d = SIGN;
        end
      end
      HUND: begin
        if (xfer_s) begin
          state_d   = TENS;
          tx_data_d = ascii_digit(tens_q);
        end else begin
          state_d = HUND;
        end
      end
      TENS: begin
        if (xfer_s) begin
          state_d   = ONES;
          tx_data_d = ascii_digit(ones_q);
        end else begin
          state_d = TENS;
        end
      end
      ONES: begin
        if (xfer_s && last_col_s) begin
          state_d   = CR;
          tx_data_d = ASCII_CR;
        end else if (xfer_s) begin
          state_d   = SEP;
          tx_data_d = SEP_CHAR;
        end else begin
          state_d = ONES;
        end
      end
      SEP: begin
        if (xfer_s) begin
          col_d     = col_q + CIDX_W'(1);
          state_d   = nstep_s.st;
          tx_data_d = nstep_s.data;
          ld_dig_s  = 1'b1;
        end else begin
          state_d = SEP;
        end
      end
      CR: begin
        if (xfer_s) begin
          state_d   = LF;
          tx_data_d = ASCII_LF;
        end else begin
          state_d = CR;
        end
      end
      LF: begin
        if (xfer_s && (err_q || last_row_s)) begin
          state_d    = DONE;
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else if (xfer_s) begin
          row_d     = row_q + RIDX_W'(1);
          col_d     = '0;
          state_d   = nstep_s.st;
          tx_data_d = nstep_s.data;
          ld_dig_s  = 1'b1;
        end else begin
          state_d = LF;
        end
      end
      // col_q doubles as the index into "ERR"; it is idle on this path.
      ERR_MSG: begin
        if (xfer_s && (col_q == CIDX_W'(ERR_LEN - 1))) begin
          state_d   = CR;
          tx_data_d = ASCII_CR;
          col_d     = '0;
        end else if (xfer_s) begin
          col_d     = col_q + CIDX_W'(1);
          tx_data_d = err_byte(col_q[1:0] + 2'd1);
        end else begin
          state_d = ERR_MSG;
        end
      end
      DONE: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        tx_valid_d = 1'b0;
      end
      default: begin
        state_d    = IDLE;
        tx_data_d  = 8'h00;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State, output, counter, snapshot and digit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      cells_q    <= '0;
      err_q      <= 1'b0;
      neg_q      <= 1'b0;
      hund_q     <= 4'd0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      ndig_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      row_q      <= row_d;
      col_q      <= col_d;
      if (ld_snap_s) begin
        rows_q  <= rows_in_s;
        cols_q  <= cols_in_s;
        cells_q <= result_matrix.cells;
        err_q   <= error_flag | ~result_matrix.is_valid;
      end
      if (ld_dig_s) begin
        neg_q  <= nd_neg_s;
        hund_q <= nd_hund_s;
        tens_q <= nd_tens_s;
        ones_q <= nd_ones_s;
        ndig_q <= nd_ndig_s;
      end
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_matrix_result_printer.sv
// Directed, table-driven bench for matrix_result_printer with hand-computed byte strings.
module tb_matrix_result_printer;
  import project_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  matrix_t    result_matrix;
  logic       error_flag;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [15:0] NL = 16'h0D0A;

  typedef struct packed {
    logic [3:0]       rows;
    logic [3:0]       cols;
    logic [0:5][7:0]  el;     // row-major elements
    logic             err;
    logic             valid;
    logic             stall;  // toggle tx_ready
    logic             poke;   // second start with altered matrix mid-print
    logic [7:0]       len;
    logic [191:0]     exp;
  } vec_t;

  vec_t vecs[11];

  matrix_result_printer #(.SEP_CHAR(8'h20)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .result_matrix (result_matrix),
    .error_flag    (error_flag),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Starts one print at the next negedge and collects bytes until done; returns
  // at the negedge where done is observed (or after the cycle budget).
  task automatic run_print(input vec_t v);
    matrix_t      m;
    logic [191:0] got;
    int           nb, done_cyc;
    logic         pv, pr, fin;
    logic [7:0]   pd;
    m = '0;
    m.rows = v.rows;
    m.cols = v.cols;
    m.is_valid = v.valid;
    for (int r = 0; r < int'(v.rows); r++)
      for (int c = 0; c < int'(v.cols); c++)
        if (r * int'(v.cols) + c < 6) m.cells[r][c] = v.el[r * int'(v.cols) + c];
    @(negedge clk);
    result_matrix = m;
    error_flag    = v.err;
    start         = 1'b1;
    tx_ready      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = '0; nb = 0; done_cyc = 0; pv = 1'b0; pr = 1'b1; pd = 8'h00; fin = 1'b0;
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      if (cyc > 1) @(negedge clk);
      tx_ready = v.stall ? ((cyc % 2) == 1) : 1'b1;
      if (cyc == 1) begin
        if (v.len == 8'd0) chk("empty_first", 192'({tx_valid, done}), 192'(2'b01));
        else chk("first_byte", 192'({tx_valid, tx_data}), 192'({1'b1, v.exp[8*(int'(v.len)-1) +: 8]}));
      end
      if (pv && !pr) chk("stall_hold", 192'({tx_valid, tx_data}), 192'({1'b1, pd}));
      if (v.poke && cyc == 3) begin
        chk("busy_mid", 192'(busy), 192'(1'b1));
        result_matrix.rows = 4'd1;
        result_matrix.cols = 4'd1;
        result_matrix.cells[0][0] = 8'sd7;
        result_matrix.cells[0][1] = 8'sd7;
        error_flag = 1'b1;
        start = 1'b1;
      end
      if (v.poke && cyc == 4) start = 1'b0;
      if (tx_valid && tx_ready) begin
        got = {got[183:0], tx_data};
        nb++;
      end
      if (done) begin
        chk("done_idle", 192'({busy, tx_valid}), 192'(2'b00));
        done_cyc = cyc;
        fin = 1'b1;
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
    end
    chk("done_seen", 192'(fin), 192'(1'b1));
    chk("bytes", got, v.exp);
    chk("byte_count", 192'(nb), 192'(v.len));
    if (!v.stall) chk("latency", 192'(done_cyc), 192'(int'(v.len) + 1));
  endtask

  initial begin
    matrix_t big;
    rst_n = 1'b0; start = 1'b0; tx_ready = 1'b0; error_flag = 1'b0; result_matrix = '0;

    vecs[0]  = '{4'd2, 4'd2, {8'd1, 8'hFE, 8'd127, 8'h80, 8'd0, 8'd0}, 1'b0, 1'b1, 1'b0, 1'b0, 8'd16,
                 192'({"1 -2", NL, "127 -128", NL})};
    vecs[1]  = '{4'd1, 4'd1, {8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5,
                 192'({"ERR", NL})};
    vecs[2]  = '{4'd2, 4'd2, {8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0}, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5,
                 192'({"ERR", NL})};
    vecs[3]  = '{4'd1, 4'd3, {8'd0, 8'd10, 8'h9C, 8'd0, 8'd0, 8'd0}, 1'b0, 1'b1, 1'b1, 1'b0, 8'd11,
                 192'({"0 10 -100", NL})};
    vecs[4]  = '{4'd2, 4'd1, {8'd99, 8'hF7, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 1'b1, 1'b0, 1'b0, 8'd8,
                 192'({"99", NL, "-9", NL})};
    vecs[5]  = '{4'd1, 4'd2, {8'd100, 8'hF6, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 1'b1, 1'b1, 1'b0, 8'd9,
                 192'({"100 -10", NL})};
    vecs[6]  = '{4'd2, 4'd2, {8'd1, 8'hFE, 8'd127, 8'h80, 8'd0, 8'd0}, 1'b0, 1'b1, 1'b0, 1'b1, 8'd16,
                 192'({"1 -2", NL, "127 -128", NL})};
    vecs[7]  = '{4'd0, 4'd3, {8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0}, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 192'(0)};
    vecs[8]  = '{4'd2, 4'd0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 192'(0)};
    vecs[9]  = '{4'd0, 4'd0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5,
                 192'({"ERR", NL})};
    vecs[10] = '{4'd1, 4'd1, {8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3,
                 192'({"5", NL})};

    repeat (2) @(negedge clk);
    chk("reset_state", 192'({tx_valid, tx_data, busy, done}), 192'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_print(vecs[i]);

    // A start presented during the DONE cycle must be ignored.
    run_print(vecs[4]);
    result_matrix = '0;
    result_matrix.rows = 4'd1;
    result_matrix.cols = 4'd1;
    result_matrix.is_valid = 1'b1;
    result_matrix.cells[0][0] = 8'sd5;
    error_flag = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("start_in_done", 192'({tx_valid, busy, done}), 192'(0));
      @(negedge clk);
    end

    // Reset after the third byte of an 8x10 print abandons it.
    big = '0;
    big.rows = 4'd8;
    big.cols = 4'd10;
    big.is_valid = 1'b1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++) big.cells[r][c] = 8'sd11;
    result_matrix = big;
    error_flag = 1'b0;
    tx_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", 192'({tx_valid, busy}), 192'(2'b11));
    rst_n = 1'b0;
    #1;
    chk("rst_abort", 192'({tx_valid, tx_data, busy, done}), 192'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_reset_quiet", 192'({tx_valid, done}), 192'(0));
    end
    run_print(vecs[10]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
